// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: program counter, two-phase FSM and instruction register
// feeding decode, with ROM wait-state handshake and execute stall.
module fetch_sequencer #(
  parameter int unsigned     ADDR_W     = 12,
  parameter int unsigned     DATA_W     = 8,
  parameter int unsigned     OPC_W      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    Rst,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  input  logic                    rom_ready,
  input  logic                    stall,
  input  logic                    incPC,
  input  logic                    loadPC,
  input  logic [ADDR_W-1:0]       newaddr,
  output logic [ADDR_W-1:0]       pc,
  output logic                    phase,
  output logic [OPC_W-1:0]        instruction,
  output logic [DATA_W-OPC_W-1:0] operand,
  output logic                    instr_valid
);

  localparam int unsigned OPR_W = DATA_W - OPC_W;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   pc_inc;

  // Modulo increment; all-ones wraps to zero silently.
  assign pc_inc = pc_q + ADDR_W'(1);

  // State, PC and IR registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_ADDR;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; instr_valid marks an execute cycle that completes this edge.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    instr_valid = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (rom_ready) begin
          ir_d    = rom_data;
          pc_d    = pc_inc;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (loadPC) begin
            pc_d        = newaddr;
            state_d     = FETCH;
            instr_valid = 1'b1;
          end else if (incPC) begin
            // Operand byte must be consumed before the PC may move past it.
            if (rom_ready) begin
              pc_d        = pc_inc;
              state_d     = FETCH;
              instr_valid = 1'b1;
            end
          end else begin
            state_d     = FETCH;
            instr_valid = 1'b1;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign phase       = (state_q == EXEC);
  assign instruction = ir_q[DATA_W-1 -: OPC_W];
  assign operand     = ir_q[OPR_W-1:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected pc/phase/IR pushed per driven cycle,
// popped and compared after the clock edge; instr_valid checked before the edge.
module tb_fetch_sequencer;

  logic        clk;
  logic        Rst;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ready;
  logic        stall;
  logic        incPC;
  logic        loadPC;
  logic [11:0] newaddr;
  logic [11:0] pc;
  logic        phase;
  logic [3:0]  instruction;
  logic [3:0]  operand;
  logic        instr_valid;

  typedef struct packed {
    logic [11:0] pc;
    logic        phase;
    logic [7:0]  ir;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  rom [0:4095];
  int          n_checks = 0;
  int          n_errors = 0;
  int          step_no  = 0;

  fetch_sequencer #(
    .ADDR_W(12), .DATA_W(8), .OPC_W(4), .RESET_ADDR(12'h000)
  ) dut (
    .clk(clk), .Rst(Rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_ready(rom_ready), .stall(stall), .incPC(incPC), .loadPC(loadPC),
    .newaddr(newaddr), .pc(pc), .phase(phase), .instruction(instruction),
    .operand(operand), .instr_valid(instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Poisoned data while not ready exposes any premature IR load.
  assign rom_data = rom_ready ? rom[rom_addr] : 8'hEE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic st, input logic inc,
                     input logic ld, input logic [11:0] na, input logic chk_v,
                     input logic ev, input logic [11:0] epc, input logic eph,
                     input logic [7:0] eir);
    exp_t e;
    step_no++;
    Rst = r; rom_ready = rdy; stall = st; incPC = inc; loadPC = ld; newaddr = na;
    @(negedge clk);
    if (chk_v) check($sformatf("s%0d_instr_valid", step_no), 32'(instr_valid), 32'(ev));
    sb.push_back('{pc: epc, phase: eph, ir: eir});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("s%0d_pc", step_no),          32'(pc),          32'(e.pc));
    check($sformatf("s%0d_rom_addr", step_no),    32'(rom_addr),    32'(e.pc));
    check($sformatf("s%0d_phase", step_no),       32'(phase),       32'(e.phase));
    check($sformatf("s%0d_instruction", step_no), 32'(instruction), 32'(e.ir[7:4]));
    check($sformatf("s%0d_operand", step_no),     32'(operand),     32'(e.ir[3:0]));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h1A;
    rom[12'h001] = 8'h2B;
    rom[12'h005] = 8'h5C;
    rom[12'h007] = 8'h7D;
    rom[12'h3F0] = 8'h9E;
    rom[12'hFFF] = 8'hF7;
    Rst = 1'b0; rom_ready = 1'b1; stall = 1'b0; incPC = 1'b0; loadPC = 1'b0;
    newaddr = 12'h000;
    #1;
    //  r  rdy st inc ld newaddr  chk ev  pc       ph  ir
    cyc(0, 1, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 8'h00);
    // straight line, combinational ROM
    cyc(1, 1, 0, 0, 0, 12'h000, 1, 0, 12'h001, 1, 8'h1A);
    cyc(1, 1, 0, 0, 0, 12'h000, 1, 1, 12'h001, 0, 8'h1A);
    cyc(1, 1, 0, 0, 0, 12'h000, 1, 0, 12'h002, 1, 8'h2B);
    cyc(1, 1, 0, 0, 1, 12'h005, 1, 1, 12'h005, 0, 8'h2B);
    // ROM wait states in FETCH
    cyc(1, 0, 0, 0, 0, 12'h000, 1, 0, 12'h005, 0, 8'h2B);
    cyc(1, 0, 1, 1, 1, 12'h123, 1, 0, 12'h005, 0, 8'h2B);
    cyc(1, 0, 0, 0, 0, 12'h000, 1, 0, 12'h005, 0, 8'h2B);
    cyc(1, 1, 0, 0, 0, 12'h000, 1, 0, 12'h006, 1, 8'h5C);
    // incPC waits for ROM ready in EXEC
    cyc(1, 0, 0, 1, 0, 12'h000, 1, 0, 12'h006, 1, 8'h5C);
    cyc(1, 1, 0, 1, 0, 12'h000, 1, 1, 12'h007, 0, 8'h5C);
    cyc(1, 1, 0, 0, 0, 12'h000, 1, 0, 12'h008, 1, 8'h7D);
    // loadPC wins over incPC, no ready needed
    cyc(1, 0, 0, 1, 1, 12'h3F0, 1, 1, 12'h3F0, 0, 8'h7D);
    cyc(1, 1, 0, 0, 0, 12'h000, 1, 0, 12'h3F1, 1, 8'h9E);
    cyc(1, 1, 0, 0, 1, 12'hFFF, 1, 1, 12'hFFF, 0, 8'h9E);
    // fetch at all-ones wraps, controls ignored in FETCH
    cyc(1, 1, 1, 1, 1, 12'h123, 1, 0, 12'h000, 1, 8'hF7);
    // two stall cycles then release
    cyc(1, 1, 1, 1, 0, 12'h000, 1, 0, 12'h000, 1, 8'hF7);
    cyc(1, 1, 1, 0, 1, 12'h222, 1, 0, 12'h000, 1, 8'hF7);
    cyc(1, 1, 0, 0, 0, 12'h000, 1, 1, 12'h000, 0, 8'hF7);
    // reset during an EXEC stall
    cyc(1, 1, 0, 0, 0, 12'h000, 1, 0, 12'h001, 1, 8'h1A);
    cyc(0, 1, 1, 1, 1, 12'h444, 1, 0, 12'h000, 0, 8'h00);
    cyc(1, 1, 0, 0, 0, 12'h000, 1, 0, 12'h001, 1, 8'h1A);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
